// File: rtl/tp_mem_port_ctrl_1024_32.sv
// tp_mem_port_ctrl_1024_32
// Request/response front end for a single-port synchronous RAM (registered
// read data, one edge after the address). Reads are tagged with a 1-bit
// pending flag and their data is captured into a small response FIFO.
// Request acceptance is credit-based, so the FIFO can never overflow.
//
// Optional build macro: TP_MEM_PORT_WRACK_EN
//   When defined, writes also produce a response carrying the written data,
//   which the RAM returns write-first with the same latency as a read.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid && ready are both high. ready never depends on valid.
// A producer holds valid and its payload stable until the transfer.
// Response payload is meaningless while rsp_valid is low.
module tp_mem_port_ctrl_1024_32 #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_wr_cnt
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic                pending;
  logic [DATA_W-1:0]   fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W:0]      credit_used;
  logic                fire;
  logic                set_pending;
  logic                push;
  logic                pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits: queued responses plus the one in flight from the RAM.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pending};
  assign req_ready   = credit_used < (CNT_W + 1)'(RSP_DEPTH);
  assign fire        = req_valid && req_ready;

  // RAM port is a straight pass-through; only the write strobe is gated.
  assign mem_addr    = req_addr;
  assign mem_data_in = req_wdata;
  assign mem_wen     = fire && req_wen;

`ifdef TP_MEM_PORT_WRACK_EN
  assign set_pending = fire;
`else
  assign set_pending = fire && !req_wen;
`endif

  assign push      = pending;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = fifo_mem[rd_ptr];

  // Pending marks that mem_data_out holds response data on the next edge.
  always_ff @(posedge clk) begin
    if (rst) pending <= 1'b0;
    else     pending <= set_pending;
  end

  // Response storage; nothing is captured on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wr_ptr] <= mem_data_out;
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Accepted-request statistics, free-running 16-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else begin
      if (fire && !req_wen) stat_rd_cnt <= stat_rd_cnt + 16'd1;
      if (fire && req_wen)  stat_wr_cnt <= stat_wr_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tp_mem_port_ctrl_1024_32.sv
// Bench for tp_mem_port_ctrl_1024_32 with a write-first registered RAM model.
// Responses are checked through an expected-data queue; directed steps check
// reset state, latency, backpressure, address wrap, mid-op reset and the
// statistics counters. Honours TP_MEM_PORT_WRACK_EN like the design.
module tb_tp_mem_port_ctrl_1024_32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        mem_wen;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = '0;
  logic [15:0] stat_rd_cnt;
  logic [15:0] stat_wr_cnt;

  logic [31:0] ram    [1024];
  logic [31:0] shadow [1024];
  logic [31:0] exp_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  tp_mem_port_ctrl_1024_32 dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // RAM model: registered read, write-first.
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_data_in;
    mem_data_out <= mem_wen ? mem_data_in : ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // scoreboard: push expectations on fire, pop on response transfer
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt = total_cnt + 1;
          $error("FAIL rsp_unexpected observed=%h expected=none", rsp_rdata);
        end else begin
          check("rsp_data", rsp_rdata, exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        if (req_wen) begin
          shadow[req_addr] = req_wdata;
`ifdef TP_MEM_PORT_WRACK_EN
          exp_q.push_back(req_wdata);
`endif
        end else begin
          exp_q.push_back(shadow[req_addr]);
        end
      end
    end
  end

  // driver tasks (called just after a rising edge)
  task automatic issue(input logic wen, input logic [9:0] addr, input logic [31:0] data);
    bit done = 0;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = data;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1;
    end
    if (!done) begin
      total_cnt = total_cnt + 1;
      $error("FAIL issue_timeout observed=stalled expected=fire addr=%h", addr);
    end else begin
      check("mem_wen", {31'd0, mem_wen}, {31'd0, wen});
      check("mem_addr", {22'd0, mem_addr}, {22'd0, addr});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_wen   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_req_ready", {31'd0, req_ready}, 1);
    check("rst_mem_wen", {31'd0, mem_wen}, 0);
    check("rst_rd_cnt", {16'd0, stat_rd_cnt}, 0);
    check("rst_wr_cnt", {16'd0, stat_wr_cnt}, 0);

    // write then read same word; response after the second edge
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue(1'b1, 10'h005, 32'hDEADBEEF);
    issue(1'b0, 10'h005, 32'h0);
    idle();
    @(negedge clk);
`ifndef TP_MEM_PORT_WRACK_EN
    check("lat_not_yet", {31'd0, rsp_valid}, 0);
`endif
    @(negedge clk);
    check("lat_valid", {31'd0, rsp_valid}, 1);
    check("lat_data", rsp_rdata, 32'hDEADBEEF);
    check("wr_cnt_1", {16'd0, stat_wr_cnt}, 1);
    check("rd_cnt_1", {16'd0, stat_rd_cnt}, 1);
    drain();

    // backpressure: two reads fill the credits, the third stalls
    @(posedge clk); #1;
    issue(1'b1, 10'h000, 32'h11);
    issue(1'b1, 10'h001, 32'h22);
    issue(1'b1, 10'h002, 32'h33);
    idle();
    drain();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(1'b0, 10'h000, 32'h0);
    issue(1'b0, 10'h001, 32'h0);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 10'h002;
    @(negedge clk);
    check("bp_ready_low", {31'd0, req_ready}, 0);
    repeat (4) @(negedge clk);
    check("bp_still_low", {31'd0, req_ready}, 0);
    check("bp_rd_cnt", {16'd0, stat_rd_cnt}, 3);
    check("bp_head_valid", {31'd0, rsp_valid}, 1);
    check("bp_head_data", rsp_rdata, 32'h11);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue(1'b0, 10'h002, 32'h0);
    idle();
    drain();
    check("bp_rd_cnt_after", {16'd0, stat_rd_cnt}, 4);

    // full address sweep with wrap
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] d;
      d = 32'hC0DE0000 ^ (i << 20) ^ i;
      issue(1'b1, i[9:0], d);
    end
    idle();
    drain();
    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++) issue(1'b0, i[9:0], 32'h0);
    idle();
    @(negedge clk);
    check("sweep_rd_cnt", {16'd0, stat_rd_cnt}, 1024);
    @(posedge clk); #1;
    for (int i = 1024; i < 1028; i++) issue(1'b0, i[9:0], 32'h0);
    idle();
    drain();
    check("wrap_rd_cnt", {16'd0, stat_rd_cnt}, 1028);

    // reset right after a read fires
    @(posedge clk); #1;
    issue(1'b0, 10'h010, 32'h0);
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_rsp", {31'd0, rsp_valid}, 0);
    end
    check("midrst_ready", {31'd0, req_ready}, 1);
    check("midrst_rd_cnt", {16'd0, stat_rd_cnt}, 0);
    check("midrst_wr_cnt", {16'd0, stat_wr_cnt}, 0);

    // write to top address: response only with write-ack build
    @(posedge clk); #1;
    issue(1'b1, 10'h3FF, 32'hA5A5A5A5);
    idle();
    @(negedge clk);
`ifdef TP_MEM_PORT_WRACK_EN
    @(negedge clk);
    check("wrack_valid", {31'd0, rsp_valid}, 1);
    check("wrack_data", rsp_rdata, 32'hA5A5A5A5);
`else
    check("nowrack_ready", {31'd0, req_ready}, 1);
    @(negedge clk);
    check("nowrack_no_rsp", {31'd0, rsp_valid}, 0);
`endif
    drain();

    // write counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) issue(1'b1, i[9:0], i);
    idle();
    @(negedge clk);
    check("wr_cnt_ffff", {16'd0, stat_wr_cnt}, 32'h0000FFFF);
    @(posedge clk); #1;
    issue(1'b1, 10'h3FF, 32'h5A5A5A5A);
    idle();
    @(negedge clk);
    check("wr_cnt_wrap", {16'd0, stat_wr_cnt}, 0);
    check("wr_wrap_rd_cnt", {16'd0, stat_rd_cnt}, 0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
